alu_arbiter: RTL

Shares one single-cycle combinational ALU (4-bit control, 32-bit A/B, `zero`/`ovf` flags) between `NREQ` requesters. Each requester issues an operation over a valid/ready handshake. The arbiter registers the winner's operands, drives the shared ALU for one cycle and captures the result and flags. It then returns them on a single tagged response channel. It sits between the issue logic of the execution units and the ALU instance.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters. Each operation is accepted
// over valid/ready, executed for one cycle and returned on a tagged response channel.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_ctrl,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [3:0]           alu_ctrl,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  input  logic [31:0]          alu_do,
  input  logic                 alu_zero,
  input  logic                 alu_ovf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       ctrl_arr [NREQ];
  logic [31:0]      a_arr    [NREQ];
  logic [31:0]      b_arr    [NREQ];
  logic             grant_ok;
  logic             handshake;
  logic [IDW-1:0]   winner;

  logic [3:0]       op_ctrl_reg;
  logic [31:0]      op_a_reg, op_b_reg;
  logic [IDW-1:0]   op_id_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [31:0]      rsp_data_reg;
  logic             rsp_zero_reg, rsp_ovf_reg;

  // A new grant may overlap the cycle in which the held response is consumed.
  assign grant_ok  = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
  assign handshake = |req_ready;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign ctrl_arr[gi]  = req_ctrl[4*gi +: 4];
      assign a_arr[gi]     = req_a[32*gi +: 32];
      assign b_arr[gi]     = req_b[32*gi +: 32];
      assign req_ready[gi] = rst_n && grant_ok && req_valid[gi] && (winner == IDW'(gi));
    end
  endgenerate

`ifdef ALU_ARB_RR_EN
  logic [IDW-1:0] last_grant_reg;
  int             idx;

  // Scan offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    winner = last_grant_reg;
    idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant_reg) + k) % NREQ;
      if (req_valid[idx]) winner = IDW'(idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_grant_reg <= IDW'(NREQ - 1);
    else if (handshake) last_grant_reg <= winner;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = IDW'(i);
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = handshake ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_ctrl_reg  <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      op_id_reg    <= '0;
      rsp_id_reg   <= '0;
      rsp_data_reg <= '0;
      rsp_zero_reg <= 1'b0;
      rsp_ovf_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        op_ctrl_reg <= ctrl_arr[winner];
        op_a_reg    <= a_arr[winner];
        op_b_reg    <= b_arr[winner];
        op_id_reg   <= winner;
      end
      if (state_reg == EXEC) begin
        rsp_id_reg   <= op_id_reg;
        rsp_data_reg <= alu_do;
        rsp_zero_reg <= alu_zero;
        rsp_ovf_reg  <= alu_ovf;
      end
    end
  end

  assign alu_ctrl  = op_ctrl_reg;
  assign alu_a     = op_a_reg;
  assign alu_b     = op_b_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_ovf   = rsp_ovf_reg;

endmodule
